// File: rtl/tetris_pkg.sv
// Shared constants and scan-state type for the Tetris chip board reader.
package tetris_pkg;
  localparam int         NUM_COLS  = 8;
  localparam logic [3:0] SCORE_LOC = 4'b1000;
  localparam logic [3:0] DROP_IDLE = 4'd9;
  localparam logic [3:0] MAX_STACK = 4'd8;
  localparam int         VIS_ROWS  = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_e;
endpackage

// File: rtl/tetris_board_reader_pin_sync.sv
// Two-flop synchronizer for the chip's asynchronous output pins.
module pin_sync #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;
endmodule

// File: rtl/tetris_board_reader.sv
// Scans the chip's location-multiplexed port into a shadow frame, validates it,
// commits it atomically, and serves a registered pixel lookup from the committed frame.
module tetris_board_reader
  import tetris_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] chip_out,
  output logic [3:0]  req_loc,
  output logic        frame_valid,
  output logic [7:0]  score,
  output logic        running,
  output logic [2:0]  cursor,
  output logic [7:0]  frame_count,
  output logic [7:0]  err_count,
  input  logic [3:0]  pix_row,
  input  logic [2:0]  pix_col,
  output logic        pix_on
);
  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  logic [11:0] sync_dat;
  logic [7:0]  value;

  pin_sync #(.WIDTH(12)) u_pin_sync (
    .clock (clock),
    .reset (reset),
    .din   (chip_out),
    .dout  (sync_dat)
  );
  assign value = sync_dat[11:4];

  scan_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  loc_q, loc_d;

  logic [3:0]  sh_stack_q [NUM_COLS];
  logic [3:0]  sh_stack_d [NUM_COLS];
  logic [3:0]  sh_drop_q  [NUM_COLS];
  logic [3:0]  sh_drop_d  [NUM_COLS];
  logic [7:0]  sh_score_q, sh_score_d;
  logic        sh_run_q, sh_run_d;
  logic [2:0]  sh_cur_q, sh_cur_d;

  logic [3:0]  stack_q [NUM_COLS];
  logic [3:0]  stack_d [NUM_COLS];
  logic [3:0]  drop_q  [NUM_COLS];
  logic [3:0]  drop_d  [NUM_COLS];
  logic [7:0]  score_q, score_d;
  logic        running_q, running_d;
  logic [2:0]  cursor_q, cursor_d;
  logic        frame_valid_q, frame_valid_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        pix_on_q, pix_on_d;

  logic        frame_ok;
  logic [4:0]  pix_h;

  // A single bad column poisons the whole frame so the display never shows a mixed board.
  always_comb begin
    frame_ok = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (sh_stack_q[c] > MAX_STACK || sh_drop_q[c] == 4'd0 ||
          sh_drop_q[c] > DROP_IDLE || sh_drop_q[c] <= sh_stack_q[c]) begin
        frame_ok = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    loc_d         = loc_q;
    sh_stack_d    = sh_stack_q;
    sh_drop_d     = sh_drop_q;
    sh_score_d    = sh_score_q;
    sh_run_d      = sh_run_q;
    sh_cur_d      = sh_cur_q;
    stack_d       = stack_q;
    drop_d        = drop_q;
    score_d       = score_q;
    running_d     = running_q;
    cursor_d      = cursor_q;
    frame_valid_d = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          loc_d   = 4'd0;
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (loc_q == SCORE_LOC) begin
          sh_score_d = value;
          sh_run_d   = sync_dat[0];
          sh_cur_d   = sync_dat[3:1];
          state_d    = ST_COMMIT;
        end else begin
          sh_stack_d[loc_q[2:0]] = value[3:0];
          sh_drop_d[loc_q[2:0]]  = value[7:4];
          loc_d   = loc_q + 4'd1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        if (frame_ok) begin
          stack_d       = sh_stack_q;
          drop_d        = sh_drop_q;
          score_d       = sh_score_q;
          running_d     = sh_run_q;
          cursor_d      = sh_cur_q;
          frame_valid_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end
        loc_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Row r of the display corresponds to height r+1; the top visible row also shows the cursor.
  always_comb begin
    pix_h    = {1'b0, pix_row} + 5'd1;
    pix_on_d = 1'b0;
    if (pix_h <= 5'(VIS_ROWS)) begin
      pix_on_d = (pix_h <= {1'b0, stack_q[pix_col]}) |
                 (pix_h == {1'b0, drop_q[pix_col]}) |
                 ((pix_h == 5'(VIS_ROWS)) & running_q & (cursor_q == pix_col));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      loc_q         <= 4'd0;
      for (int c = 0; c < NUM_COLS; c++) begin
        stack_q[c] <= 4'd0;
        drop_q[c]  <= DROP_IDLE;
      end
      score_q       <= 8'd0;
      running_q     <= 1'b0;
      cursor_q      <= 3'd0;
      frame_valid_q <= 1'b0;
      frame_count_q <= 8'd0;
      err_count_q   <= 8'd0;
      pix_on_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      loc_q         <= loc_d;
      stack_q       <= stack_d;
      drop_q        <= drop_d;
      score_q       <= score_d;
      running_q     <= running_d;
      cursor_q      <= cursor_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      pix_on_q      <= pix_on_d;
    end
  end

  // Shadow contents are always fully rewritten before a commit, so they need no reset.
  always_ff @(posedge clock) begin
    sh_stack_q <= sh_stack_d;
    sh_drop_q  <= sh_drop_d;
    sh_score_q <= sh_score_d;
    sh_run_q   <= sh_run_d;
    sh_cur_q   <= sh_cur_d;
  end

  assign req_loc     = loc_q;
  assign frame_valid = frame_valid_q;
  assign score       = score_q;
  assign running     = running_q;
  assign cursor      = cursor_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign pix_on      = pix_on_q;
endmodule
